// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares one tagged memory port between the icache (fetch misses) and the
//   dcache (load/store misses). One requester is granted per cycle, the
//   memory's accept tag is forwarded to the winner only, and each accepted
//   load tag is recorded with its owner so returning lines are routed back.
//   Instruction returns made stale by a fetch redirect are dropped.
//
// Ports
//   clock, reset            system clock, asynchronous active-low reset
//   icache_command/addr     fetch request (BUS_NONE / BUS_LOAD)
//   icache_flush            fetch redirect: stales all outstanding I loads
//   dcache_command/addr/data  data request (BUS_NONE / BUS_LOAD / BUS_STORE)
//   mem2proc_response       accept tag for this cycle's request, 0 = reject
//   mem2proc_data/tag       returning line and its tag, tag 0 = none
//   proc2mem_command/addr/data  request forwarded to memory
//   icache_response/dcache_response  accept tag, only to the granted side
//   icache_data_valid/data/tag       returning line owned by the icache
//   dcache_data_valid/dcache_data_out/dcache_tag  returning line owned by dcache
//   tag_error               sticky: a return hit an unallocated tag
module mem_bus_arbiter #(
  parameter int unsigned NUM_TAGS     = 15,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned XLEN         = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [1:0]      icache_command,
  input  logic [XLEN-1:0] icache_addr,
  input  logic            icache_flush,
  input  logic [1:0]      dcache_command,
  input  logic [XLEN-1:0] dcache_addr,
  input  logic [63:0]     dcache_data,
  input  logic [3:0]      mem2proc_response,
  input  logic [63:0]     mem2proc_data,
  input  logic [3:0]      mem2proc_tag,
  output logic [1:0]      proc2mem_command,
  output logic [XLEN-1:0] proc2mem_addr,
  output logic [63:0]     proc2mem_data,
  output logic [3:0]      icache_response,
  output logic [3:0]      dcache_response,
  output logic            icache_data_valid,
  output logic            dcache_data_valid,
  output logic [63:0]     icache_data,
  output logic [63:0]     dcache_data_out,
  output logic [3:0]      icache_tag,
  output logic [3:0]      dcache_tag,
  output logic            tag_error
);

  typedef enum logic [1:0] {
    BUS_NONE  = 2'd0,
    BUS_LOAD  = 2'd1,
    BUS_STORE = 2'd2
  } bus_cmd_e;

  localparam int unsigned SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_LIMIT);
  localparam logic [3:0]    MAX_TAG    = 4'(NUM_TAGS);

  // Owner table, one bit per tag; index 0 is never allocated.
  // owner bit: 1 = dcache, 0 = icache.
  logic [15:0]   valid_q, valid_d;
  logic [15:0]   owner_q, owner_d;
  logic [15:0]   stale_q, stale_d;
  logic [SW-1:0] streak_q, streak_d;
  logic          tag_error_q, tag_error_d;

  logic       i_req, d_req;
  logic       grant_i, grant_d;
  logic       accepted, i_acc, d_acc;
  logic       win_load;
  logic       ret_vld;
  logic       alloc;

  // ---------------- grant ----------------
  always_comb begin
    i_req    = (icache_command != BUS_NONE);
    d_req    = (dcache_command != BUS_NONE);
    grant_i  = i_req && (!d_req || (streak_q == STREAK_MAX));
    grant_d  = d_req && !grant_i;
    accepted = (mem2proc_response != 4'd0);
    i_acc    = grant_i && accepted;
    d_acc    = grant_d && accepted;
    win_load = (grant_i && (icache_command == BUS_LOAD)) ||
               (grant_d && (dcache_command == BUS_LOAD));
    ret_vld  = (mem2proc_tag != 4'd0);
    alloc    = accepted && win_load && (mem2proc_response <= MAX_TAG);
  end

  // ---------------- next state ----------------
  always_comb begin
    streak_d = streak_q;
    if (d_acc && i_req) begin
      if (streak_q != STREAK_MAX) streak_d = streak_q + 1'b1;
    end else if (i_acc || !i_req) begin
      streak_d = '0;
    end
  end

  // Flush, then return-clear, then allocate: a same-cycle return and
  // accept on one tag leaves the entry owned by the new requester.
  always_comb begin
    valid_d = valid_q;
    owner_d = owner_q;
    stale_d = stale_q;
    if (icache_flush) stale_d = stale_q | (valid_q & ~owner_q);
    if (ret_vld) begin
      valid_d[mem2proc_tag] = 1'b0;
      stale_d[mem2proc_tag] = 1'b0;
    end
    if (alloc) begin
      valid_d[mem2proc_response] = 1'b1;
      owner_d[mem2proc_response] = grant_d;
      stale_d[mem2proc_response] = 1'b0;
    end
  end

  always_comb begin
    tag_error_d = tag_error_q | (ret_vld && !valid_q[mem2proc_tag]);
  end

  // ---------------- state registers ----------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q     <= '0;
      owner_q     <= '0;
      stale_q     <= '0;
      streak_q    <= '0;
      tag_error_q <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      owner_q     <= owner_d;
      stale_q     <= stale_d;
      streak_q    <= streak_d;
      tag_error_q <= tag_error_d;
    end
  end

  // ---------------- outputs ----------------
  // Every combinational output is forced to zero while reset is held.
  always_comb begin
    proc2mem_command  = BUS_NONE;
    proc2mem_addr     = '0;
    proc2mem_data     = '0;
    icache_response   = '0;
    dcache_response   = '0;
    icache_data_valid = 1'b0;
    dcache_data_valid = 1'b0;
    icache_data       = '0;
    dcache_data_out   = '0;
    icache_tag        = '0;
    dcache_tag        = '0;
    if (reset) begin
      if (grant_i) begin
        proc2mem_command = icache_command;
        proc2mem_addr    = icache_addr;
        icache_response  = mem2proc_response;
      end else if (grant_d) begin
        proc2mem_command = dcache_command;
        proc2mem_addr    = dcache_addr;
        dcache_response  = mem2proc_response;
        if (dcache_command == BUS_STORE) proc2mem_data = dcache_data;
      end
      if (ret_vld && valid_q[mem2proc_tag]) begin
        if (owner_q[mem2proc_tag]) begin
          dcache_data_valid = 1'b1;
          dcache_data_out   = mem2proc_data;
          dcache_tag        = mem2proc_tag;
        end else if (!stale_q[mem2proc_tag]) begin
          icache_data_valid = 1'b1;
          icache_data       = mem2proc_data;
          icache_tag        = mem2proc_tag;
        end
      end
    end
  end

  assign tag_error = tag_error_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Testbench for mem_bus_arbiter: directed stimulus, a per-tag owner model
// checked on every falling clock edge, plus hand-computed literal checks.
module tb_mem_bus_arbiter;

  localparam int unsigned LIMIT = 4;
  localparam int unsigned XL    = 32;

  logic          clock;
  logic          reset;
  logic [1:0]    icache_command;
  logic [XL-1:0] icache_addr;
  logic          icache_flush;
  logic [1:0]    dcache_command;
  logic [XL-1:0] dcache_addr;
  logic [63:0]   dcache_data;
  logic [3:0]    mem2proc_response;
  logic [63:0]   mem2proc_data;
  logic [3:0]    mem2proc_tag;
  logic [1:0]    proc2mem_command;
  logic [XL-1:0] proc2mem_addr;
  logic [63:0]   proc2mem_data;
  logic [3:0]    icache_response;
  logic [3:0]    dcache_response;
  logic          icache_data_valid;
  logic          dcache_data_valid;
  logic [63:0]   icache_data;
  logic [63:0]   dcache_data_out;
  logic [3:0]    icache_tag;
  logic [3:0]    dcache_tag;
  logic          tag_error;

  mem_bus_arbiter #(.NUM_TAGS(15), .STARVE_LIMIT(LIMIT), .XLEN(XL)) dut (
    .clock(clock), .reset(reset),
    .icache_command(icache_command), .icache_addr(icache_addr), .icache_flush(icache_flush),
    .dcache_command(dcache_command), .dcache_addr(dcache_addr), .dcache_data(dcache_data),
    .mem2proc_response(mem2proc_response), .mem2proc_data(mem2proc_data), .mem2proc_tag(mem2proc_tag),
    .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr), .proc2mem_data(proc2mem_data),
    .icache_response(icache_response), .dcache_response(dcache_response),
    .icache_data_valid(icache_data_valid), .dcache_data_valid(dcache_data_valid),
    .icache_data(icache_data), .dcache_data_out(dcache_data_out),
    .icache_tag(icache_tag), .dcache_tag(dcache_tag), .tag_error(tag_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int nchk  = 0;
  int nfail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  // m_own: 0 = free, 1 = icache, 2 = dcache
  int m_own   [16];
  bit m_stale [16];
  int m_streak = 0;
  bit m_err    = 1'b0;

  function automatic int winner();
    bit ir, dr;
    ir = (icache_command != 2'd0);
    dr = (dcache_command != 2'd0);
    if (ir && dr) return (m_streak >= int'(LIMIT)) ? 1 : 2;
    if (ir) return 1;
    if (dr) return 2;
    return 0;
  endfunction

  always @(posedge clock or negedge reset) begin : model_upd
    int w;
    int rt;
    int rs;
    bit acc;
    logic [1:0] cmd;
    if (!reset) begin
      for (int t = 0; t < 16; t++) begin
        m_own[t]   = 0;
        m_stale[t] = 1'b0;
      end
      m_streak = 0;
      m_err    = 1'b0;
    end else begin
      w   = winner();
      rs  = int'(mem2proc_response);
      acc = (w != 0) && (rs != 0);
      cmd = (w == 1) ? icache_command : dcache_command;
      if (w == 2 && acc && icache_command != 2'd0)
        m_streak = (m_streak + 1 > int'(LIMIT)) ? int'(LIMIT) : m_streak + 1;
      else if ((w == 1 && acc) || icache_command == 2'd0)
        m_streak = 0;
      rt = int'(mem2proc_tag);
      if (rt != 0 && m_own[rt] == 0) m_err = 1'b1;
      if (icache_flush)
        for (int t = 0; t < 16; t++) if (m_own[t] == 1) m_stale[t] = 1'b1;
      if (rt != 0) begin
        m_own[rt]   = 0;
        m_stale[rt] = 1'b0;
      end
      if (acc && cmd == 2'd1) begin
        m_own[rs]   = w;
        m_stale[rs] = 1'b0;
      end
    end
  end

  always @(negedge clock) begin : cmp
    int w;
    int rt;
    logic [1:0]    ecmd;
    logic [XL-1:0] eaddr;
    logic [63:0]   epd, eid, edd;
    logic [3:0]    eir, edr, eit, edt;
    bit            eiv, edv;
    w = winner();
    rt = int'(mem2proc_tag);
    ecmd = 2'd0; eaddr = '0; epd = '0; eir = '0; edr = '0;
    eiv = 1'b0; edv = 1'b0; eid = '0; edd = '0; eit = '0; edt = '0;
    if (reset) begin
      if (w == 1) begin
        ecmd = icache_command; eaddr = icache_addr; eir = mem2proc_response;
      end else if (w == 2) begin
        ecmd = dcache_command; eaddr = dcache_addr; edr = mem2proc_response;
        if (dcache_command == 2'd2) epd = dcache_data;
      end
      if (rt != 0 && m_own[rt] == 2) begin
        edv = 1'b1; edd = mem2proc_data; edt = mem2proc_tag;
      end
      if (rt != 0 && m_own[rt] == 1 && !m_stale[rt]) begin
        eiv = 1'b1; eid = mem2proc_data; eit = mem2proc_tag;
      end
    end
    check("p2m_cmd", 64'(proc2mem_command), 64'(ecmd));
    if (!reset || w != 0) check("p2m_addr", 64'(proc2mem_addr), 64'(eaddr));
    check("p2m_data", proc2mem_data, epd);
    check("i_resp", 64'(icache_response), 64'(eir));
    check("d_resp", 64'(dcache_response), 64'(edr));
    check("i_valid", 64'(icache_data_valid), 64'(eiv));
    check("d_valid", 64'(dcache_data_valid), 64'(edv));
    check("i_data", icache_data, eid);
    check("d_data", dcache_data_out, edd);
    check("i_tag", 64'(icache_tag), 64'(eit));
    check("d_tag", 64'(dcache_tag), 64'(edt));
    check("tag_error", 64'(tag_error), 64'(m_err));
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    icache_command = 2'd0; icache_addr = '0; icache_flush = 1'b0;
    dcache_command = 2'd0; dcache_addr = '0; dcache_data = '0;
    mem2proc_response = 4'd0; mem2proc_data = '0; mem2proc_tag = 4'd0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    idle();
    icache_command = 2'd1; mem2proc_response = 4'd6;   // ignored in reset
    #2;
    check("rst_cmd", 64'(proc2mem_command), 64'd0);
    check("rst_iresp", 64'(icache_response), 64'd0);
    check("rst_err", 64'(tag_error), 64'd0);
    tick(); tick();
    idle();
    reset = 1'b1;

    // I-only load, accepted on tag 3, returned two cycles later
    icache_command = 2'd1; icache_addr = 32'h100; mem2proc_response = 4'd3;
    #1;
    check("ild_iresp", 64'(icache_response), 64'd3);
    check("ild_dresp", 64'(dcache_response), 64'd0);
    check("ild_addr", 64'(proc2mem_addr), 64'h100);
    tick(); idle(); tick();
    mem2proc_tag = 4'd3; mem2proc_data = 64'hDEAD_BEEF_0000_0003;
    #1;
    check("iret_valid", 64'(icache_data_valid), 64'd1);
    check("iret_data", icache_data, 64'hDEAD_BEEF_0000_0003);
    check("iret_tag", 64'(icache_tag), 64'd3);
    check("iret_dvalid", 64'(dcache_data_valid), 64'd0);
    tick(); idle();

    // Both request every cycle: D,D,D,D,I repeating
    for (int i = 0; i < 10; i++) begin
      icache_command = 2'd1; icache_addr = 32'h200;
      dcache_command = 2'd1; dcache_addr = 32'h300;
      mem2proc_response = 4'(i + 1);
      #1;
      check("arb_addr", 64'(proc2mem_addr), (i % 5 == 4) ? 64'h200 : 64'h300);
      tick();
    end
    idle();
    for (int k = 1; k <= 10; k++) begin
      mem2proc_tag = 4'(k); mem2proc_data = 64'h1000 + 64'(k);
      #1;
      if (k == 5) check("arb_ret5_i", 64'(icache_data_valid), 64'd1);
      if (k == 1) check("arb_ret1_d", 64'(dcache_data_valid), 64'd1);
      tick();
    end
    idle();

    // D store on tag 5 allocates nothing; its return is a tag error
    dcache_command = 2'd2; dcache_addr = 32'h400; dcache_data = 64'h1234;
    mem2proc_response = 4'd5;
    #1;
    check("st_cmd", 64'(proc2mem_command), 64'd2);
    check("st_data", proc2mem_data, 64'h1234);
    check("st_dresp", 64'(dcache_response), 64'd5);
    tick(); idle(); tick();
    mem2proc_tag = 4'd5; mem2proc_data = 64'h55;
    #1;
    check("st_ret_i", 64'(icache_data_valid), 64'd0);
    check("st_ret_d", 64'(dcache_data_valid), 64'd0);
    tick(); idle();
    #1;
    check("st_err", 64'(tag_error), 64'd1);

    // Flush stales tag 2; tag 7 accepted in the flush cycle stays live
    tick();
    icache_command = 2'd1; icache_addr = 32'h500; mem2proc_response = 4'd2;
    tick(); idle(); tick();
    icache_flush = 1'b1; icache_command = 2'd1; icache_addr = 32'h508;
    mem2proc_response = 4'd7;
    #1;
    check("fl_iresp", 64'(icache_response), 64'd7);
    tick(); idle(); tick();
    mem2proc_tag = 4'd2; mem2proc_data = 64'h22;
    #1;
    check("fl_stale", 64'(icache_data_valid), 64'd0);
    tick();
    mem2proc_tag = 4'd7; mem2proc_data = 64'h77;
    #1;
    check("fl_live", 64'(icache_data_valid), 64'd1);
    check("fl_live_tag", 64'(icache_tag), 64'd7);
    tick(); idle();

    // Return and re-allocate tag 4 in the same cycle
    icache_command = 2'd1; icache_addr = 32'h600; mem2proc_response = 4'd4;
    tick(); idle(); tick();
    mem2proc_tag = 4'd4; mem2proc_data = 64'h44;
    dcache_command = 2'd1; dcache_addr = 32'h700; mem2proc_response = 4'd4;
    #1;
    check("same_ivalid", 64'(icache_data_valid), 64'd1);
    check("same_dresp", 64'(dcache_response), 64'd4);
    check("same_dvalid", 64'(dcache_data_valid), 64'd0);
    tick(); idle();
    mem2proc_tag = 4'd4; mem2proc_data = 64'h4444;
    #1;
    check("same_new_d", 64'(dcache_data_valid), 64'd1);
    check("same_new_i", 64'(icache_data_valid), 64'd0);
    tick(); idle();

    // Reset mid-cycle with tags 8 (I) and 9 (D) outstanding
    icache_command = 2'd1; icache_addr = 32'h800; mem2proc_response = 4'd8;
    tick(); idle();
    dcache_command = 2'd1; dcache_addr = 32'h900; mem2proc_response = 4'd9;
    tick(); idle();
    icache_command = 2'd1; icache_addr = 32'hA00; mem2proc_response = 4'd11;
    #2;
    reset = 1'b0;
    #1;
    check("mrst_cmd", 64'(proc2mem_command), 64'd0);
    check("mrst_iresp", 64'(icache_response), 64'd0);
    check("mrst_err", 64'(tag_error), 64'd0);
    tick(); idle();
    reset = 1'b1;
    tick();
    mem2proc_tag = 4'd8; mem2proc_data = 64'h88;
    #1;
    check("post_rst_i", 64'(icache_data_valid), 64'd0);
    tick();
    mem2proc_tag = 4'd9; mem2proc_data = 64'h99;
    #1;
    check("post_rst_d", 64'(dcache_data_valid), 64'd0);
    check("post_rst_err", 64'(tag_error), 64'd1);
    tick(); idle();
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Shares the single tagged memory port between the instruction cache (fetch misses) and the data cache (load/store misses). Picks one requester per cycle, forwards the memory's accept tag to the winner, and records which requester owns each outstanding load tag. Routes returning data to the owning cache. Drops instruction-side returns made stale by a fetch redirect. Sits between icache/dcache and the memory model.

## Interface
Parameters:
- NUM_TAGS, 15 — memory tags 1..NUM_TAGS; tag 0 means "none".
- STARVE_LIMIT, 4 — maximum consecutive contested D grants before I is forced.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low (0 = in reset)
- icache_command  in  2  BUS_NONE / BUS_LOAD (BUS_STORE never issued by icache)
- icache_addr  in  XLEN  8-byte-aligned fetch address
- icache_flush  in  1  fetch redirect; stale all outstanding I loads
- dcache_command  in  2  BUS_NONE / BUS_LOAD / BUS_STORE
- dcache_addr  in  XLEN  data address
- dcache_data  in  64  store data
- mem2proc_response  in  4  accept tag for the current request; 0 = rejected
- mem2proc_data  in  64  returning line
- mem2proc_tag  in  4  tag of returning line; 0 = none
- proc2mem_command  out  2  command to memory
- proc2mem_addr  out  XLEN  address to memory
- proc2mem_data  out  64  store data to memory; 0 unless D store granted
- icache_response / dcache_response  out  4  accept tag; 0 unless that side was granted and accepted
- icache_data_valid / dcache_data_valid  out  1  returning line belongs to this side
- icache_data / dcache_data_out  out  64  mem2proc_data when the matching valid is set, else 0
- icache_tag / dcache_tag  out  4  returning tag when the matching valid is set, else 0
- tag_error  out  1  sticky; a return arrived for an unallocated tag

## Operation
- Grant: combinational each cycle.
  - Neither side requests (command == BUS_NONE): proc2mem_command = BUS_NONE.
  - One side requests: that side wins.
  - Both request: D wins unless d_streak == STARVE_LIMIT, then I wins.
- The winner's command, address and data drive proc2mem. mem2proc_response goes only to the winner's response port; the loser sees 0 and must retry.
- d_streak (registered, saturating at STARVE_LIMIT):
  - Increments when D is accepted while I is also requesting.
  - Clears when I is accepted or I is not requesting.
  - Holds on rejection.
- Owner table: per tag 1..NUM_TAGS, stores {valid, owner(I/D), stale}.
  - Accepted BUS_LOAD (response != 0) allocates entry[response] = {1, winner, 0}.
  - Accepted BUS_STORE allocates nothing.
- Return (mem2proc_tag != 0): look up the registered table entry.
  - valid, owner D: dcache_data_valid = 1.
  - valid, owner I, not stale: icache_data_valid = 1.
  - valid, owner I, stale: no valid output; the data is silently dropped.
  - Not valid: no valid output; tag_error is set at the next edge.
  - In all cases the entry is cleared at the next edge.
- Flush: icache_flush sets stale on every entry that is valid, owned by I, at the start of the cycle.
  - An I load accepted in the same cycle allocates non-stale.
  - The I request is not blocked during flush.
- Same-cycle return and accept on the same tag: the clear is applied first, then the allocate, so the entry ends holding the new owner.

## Timing
- Grant, proc2mem outputs and response forwarding are zero-latency combinational.
- Return routing is zero-latency: valid/data/tag outputs appear in the same cycle as mem2proc_tag.
- Table, d_streak and tag_error update at posedge clock.
- A load accepted in cycle t is routable from cycle t+1. The memory return latency is at least 1.
- Reset is asynchronous: the table is invalidated, d_streak = 0 and tag_error = 0 immediately.
- While reset = 0, every output is 0 (proc2mem_command = BUS_NONE) regardless of inputs.
- Reset during outstanding loads: their later returns hit invalid entries and set tag_error. This is expected and documented for the bench.
- With all NUM_TAGS entries allocated, the arbiter still forwards requests; memory is responsible for rejecting them.

## Test plan
- I-only BUS_LOAD addr 0x100, memory accepts tag 3 -> icache_response = 3, dcache_response = 0. Later mem2proc_tag = 3 -> icache_data_valid = 1 with the data.
- Both sides request every cycle, memory always accepts -> grants follow the pattern D,D,D,D,I repeating; d_streak saturates at 4 then clears.
- D store accepted tag 5, then a return on tag 5 -> tag_error = 1 and no valid output on either side.
- I load tag 2 outstanding, icache_flush pulse, then return tag 2 -> icache_data_valid stays 0. A new I load tag 7 accepted in the flush cycle still returns valid.
- Return on tag 4 and new D load accepted on tag 4 in the same cycle -> the old owner gets the data; entry 4 then belongs to D.
- Assert reset (0) mid-cycle with two loads outstanding -> outputs go to 0 immediately; after release, both returns set tag_error and produce no valid output.
